// File: rtl/axis_out_packer_if.sv
// Stream bundle for the output packer: narrow engine-side result beats in,
// wide host-side axi_out beats out.
interface axis_out_packer_if #(
  parameter int C_IN_WIDTH  = 64,
  parameter int C_OUT_WIDTH = 512
);
  logic                     s_axis_tvalid;
  logic                     s_axis_tready;
  logic [C_IN_WIDTH-1:0]    s_axis_tdata;
  logic                     s_axis_tlast;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;
  logic [C_OUT_WIDTH-1:0]   m_axis_tdata;
  logic [C_OUT_WIDTH/8-1:0] m_axis_tkeep;
  logic                     m_axis_tlast;

  // Packer side: accepts the narrow stream and drives the wide stream.
  modport master (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );

  // Surrounding logic: produces narrow beats and consumes wide beats.
  modport slave (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );
endinterface

// File: rtl/axis_out_packer.sv
// Packs 64-bit engine result beats into 512-bit axi_out beats with tkeep/tlast,
// tracks frame length against cfg_total_beats and pulses done after the last beat.
module axis_out_packer #(
  parameter int C_IN_WIDTH  = 64,
  parameter int C_OUT_WIDTH = 512
) (
  input  logic                ap_clk,
  input  logic                areset,
  input  logic                start,
  input  logic [31:0]         cfg_total_beats,
  output logic                busy,
  output logic                done,
  output logic                err_len,
  axis_out_packer_if.master   axis
);
  localparam int LP_RATIO = C_OUT_WIDTH / C_IN_WIDTH;
  localparam int KEEP_W   = C_OUT_WIDTH / 8;
  localparam int BPB      = C_IN_WIDTH / 8;
  localparam int CNT_W    = $clog2(LP_RATIO + 1);
  localparam int LANE_W   = $clog2(C_OUT_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [C_OUT_WIDTH-1:0]  pack_data;
  logic [CNT_W-1:0]        pack_cnt;
  logic [31:0]             beats_rem;
  logic                    err_q;
  logic [C_OUT_WIDTH-1:0]  m_data;
  logic [KEEP_W-1:0]       m_keep;
  logic                    m_last;
  logic                    m_vld;

  logic                    pack_full;
  logic                    out_free;
  logic                    move;
  logic                    s_rdy;
  logic                    in_hs;
  logic                    last_in;
  logic [LANE_W-1:0]       lane_base;

  // Byte enables for a pack holding cnt input beats, low lanes first.
  function automatic logic [KEEP_W-1:0] keep_for(input logic [CNT_W-1:0] cnt);
    logic [KEEP_W-1:0] k;
    k = '0;
    for (int b = 0; b < KEEP_W; b++) k[b] = (b < int'(cnt) * BPB);
    return k;
  endfunction

  assign pack_full = (pack_cnt == CNT_W'(LP_RATIO));
  assign out_free  = !m_vld || axis.m_axis_tready;
  // In DRAIN the pack holds the frame's tail, which may be partial.
  assign move      = out_free && (pack_full || (state_q == DRAIN && pack_cnt != '0));
  assign s_rdy     = (state_q == RUN) && (!pack_full || move);
  assign in_hs     = axis.s_axis_tvalid && s_rdy;
  assign last_in   = in_hs && (axis.s_axis_tlast || beats_rem == 32'd1);
  assign lane_base = LANE_W'(pack_cnt) * LANE_W'(C_IN_WIDTH);

  always_ff @(posedge ap_clk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (cfg_total_beats == 32'd0) ? DONE : RUN;
      RUN:     if (last_in) state_d = DRAIN;
      DRAIN:   if (m_vld && axis.m_axis_tready && m_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      beats_rem <= '0;
      err_q     <= 1'b0;
      pack_data <= '0;
      pack_cnt  <= '0;
      m_data    <= '0;
      m_keep    <= '0;
      m_last    <= 1'b0;
      m_vld     <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        beats_rem <= cfg_total_beats;
        err_q     <= 1'b0;
      end else if (in_hs && beats_rem != 32'd0) begin
        beats_rem <= beats_rem - 32'd1;
      end

      // Early tlast, or count exhausted without tlast.
      if (in_hs && ((axis.s_axis_tlast && beats_rem > 32'd1) ||
                    (!axis.s_axis_tlast && beats_rem == 32'd1)))
        err_q <= 1'b1;

      if (move) begin
        pack_data <= '0;
        if (in_hs) pack_data[C_IN_WIDTH-1:0] <= axis.s_axis_tdata;
        pack_cnt  <= in_hs ? CNT_W'(1) : '0;
      end else if (in_hs) begin
        pack_data[lane_base +: C_IN_WIDTH] <= axis.s_axis_tdata;
        pack_cnt  <= pack_cnt + CNT_W'(1);
      end

      if (move) begin
        m_data <= pack_data;
        m_keep <= keep_for(pack_cnt);
        m_last <= (state_q == DRAIN);
        m_vld  <= 1'b1;
      end else if (axis.m_axis_tready) begin
        m_vld  <= 1'b0;
      end
    end
  end

  assign busy               = (state_q == RUN) || (state_q == DRAIN);
  assign done               = (state_q == DONE);
  assign err_len            = err_q;
  assign axis.s_axis_tready = s_rdy;
  assign axis.m_axis_tvalid = m_vld;
  assign axis.m_axis_tdata  = m_data;
  assign axis.m_axis_tkeep  = m_keep;
  assign axis.m_axis_tlast  = m_last;
endmodule

// File: tb/tb_axis_out_packer.sv
// Directed bench for axis_out_packer: frame packing, partial tails, backpressure,
// zero-length frames, length errors and mid-frame reset.
module tb_axis_out_packer;
  localparam int IW = 64;
  localparam int OW = 512;
  localparam int KW = OW / 8;
  localparam int R  = OW / IW;
  localparam int CYC_MAX = 400;

  logic        ap_clk = 1'b0;
  logic        areset;
  logic        start;
  logic [31:0] cfg_total_beats;
  logic        busy, done, err_len;

  axis_out_packer_if #(.C_IN_WIDTH(IW), .C_OUT_WIDTH(OW)) axis ();

  axis_out_packer #(.C_IN_WIDTH(IW), .C_OUT_WIDTH(OW)) dut (
    .ap_clk          (ap_clk),
    .areset          (areset),
    .start           (start),
    .cfg_total_beats (cfg_total_beats),
    .busy            (busy),
    .done            (done),
    .err_len         (err_len),
    .axis            (axis)
  );

  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [OW-1:0] q_data[$];
  logic [KW-1:0] q_keep[$];
  logic          q_last[$];
  int done_cnt, done_cyc, tl_cyc, vld_seen, busy_cnt, stall_cnt, stab_bad;
  int held_cnt, rdy_bad, busy_first, err_first;

  function automatic logic m_ready_for(input int mode, input int cyc);
    logic toggle;
    toggle = !((cyc % 4 == 1) || (cyc % 4 == 2));
    case (mode)
      1:       return toggle;
      2:       return (cyc < 20) ? 1'b0 : toggle;
      default: return 1'b1;
    endcase
  endfunction

  // One frame: start pulse, then per cycle drive at negedge and observe 1ns later.
  task automatic run_frame(input int cfg, input int n_send, input int mode, input int abort_at);
    int acc, cyc, n_out, stop, fill;
    logic stall, s_hs, m_hs, timed_out;
    logic [OW-1:0] pd;
    logic [KW-1:0] pk;
    logic pl;
    logic [7:0] bidx;
    q_data.delete(); q_keep.delete(); q_last.delete();
    done_cnt = 0; done_cyc = -1; tl_cyc = -1; vld_seen = 0; busy_cnt = 0;
    stall_cnt = 0; stab_bad = 0; held_cnt = 0; rdy_bad = 0;
    acc = 0; cyc = 0; n_out = 0; stop = -1; stall = 1'b0; timed_out = 1'b1;
    pd = '0; pk = '0; pl = 1'b0;
    @(negedge ap_clk);
    start = 1'b1;
    cfg_total_beats = cfg;
    while (cyc < CYC_MAX) begin
      @(negedge ap_clk);
      start = 1'b0;
      axis.m_axis_tready = m_ready_for(mode, cyc);
      bidx = acc[7:0];
      axis.s_axis_tvalid = (acc < n_send);
      axis.s_axis_tdata  = {8{bidx}};
      axis.s_axis_tlast  = (acc == n_send - 1);
      #1;
      if (cyc == 0) begin busy_first = busy; err_first = err_len; end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (stop < 0) stop = cyc + 2;
      end
      if (busy) busy_cnt++;
      if (axis.m_axis_tvalid) vld_seen++;
      if (stall && (axis.m_axis_tdata !== pd || axis.m_axis_tkeep !== pk ||
                    axis.m_axis_tlast !== pl)) stab_bad++;
      fill = acc - R * (n_out + (axis.m_axis_tvalid ? 1 : 0));
      if (axis.m_axis_tvalid && !axis.m_axis_tready && fill == R) begin
        held_cnt++;
        if (axis.s_axis_tready) rdy_bad++;
      end
      s_hs = axis.s_axis_tvalid && axis.s_axis_tready;
      m_hs = axis.m_axis_tvalid && axis.m_axis_tready;
      if (m_hs) begin
        q_data.push_back(axis.m_axis_tdata);
        q_keep.push_back(axis.m_axis_tkeep);
        q_last.push_back(axis.m_axis_tlast);
        n_out++;
        if (axis.m_axis_tlast) tl_cyc = cyc;
      end
      stall = axis.m_axis_tvalid && !axis.m_axis_tready;
      if (stall) stall_cnt++;
      pd = axis.m_axis_tdata; pk = axis.m_axis_tkeep; pl = axis.m_axis_tlast;
      if (s_hs) acc++;
      cyc++;
      if (abort_at >= 0 && acc >= abort_at) begin timed_out = 1'b0; break; end
      if (stop >= 0 && cyc > stop) begin timed_out = 1'b0; break; end
    end
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tlast  = 1'b0;
    axis.m_axis_tready = 1'b1;
    if (timed_out) check("frame_timeout", OW'(1), OW'(0));
  endtask

  // Reference packing: beat i carries byte value i in every byte, lanes low-first.
  task automatic check_frame(input string tag, input int n_send);
    int nb;
    logic [OW-1:0] ed;
    logic [KW-1:0] ek;
    logic [7:0] v;
    nb = (n_send + R - 1) / R;
    check({tag, "_nbeats"}, OW'(q_data.size()), OW'(nb));
    for (int b = 0; b < nb && b < q_data.size(); b++) begin
      ed = '0; ek = '0;
      for (int j = 0; j < R; j++) begin
        if (b * R + j < n_send) begin
          v = 8'(b * R + j);
          ed[IW*j +: IW] = {8{v}};
          ek[j*(IW/8) +: IW/8] = '1;
        end
      end
      check($sformatf("%s_data%0d", tag, b), q_data[b], ed);
      check($sformatf("%s_keep%0d", tag, b), OW'(q_keep[b]), OW'(ek));
      check($sformatf("%s_last%0d", tag, b), OW'(q_last[b]), OW'(b == nb - 1));
    end
  endtask

  initial begin
    areset = 1'b1; start = 1'b0; cfg_total_beats = '0;
    axis.s_axis_tvalid = 1'b0; axis.s_axis_tdata = '0; axis.s_axis_tlast = 1'b0;
    axis.m_axis_tready = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_busy",   OW'(busy), OW'(0));
    check("rst_done",   OW'(done), OW'(0));
    check("rst_err",    OW'(err_len), OW'(0));
    check("rst_mvalid", OW'(axis.m_axis_tvalid), OW'(0));
    check("rst_mlast",  OW'(axis.m_axis_tlast), OW'(0));
    check("rst_sready", OW'(axis.s_axis_tready), OW'(0));
    check("rst_mdata",  axis.m_axis_tdata, OW'(0));
    check("rst_mkeep",  OW'(axis.m_axis_tkeep), OW'(0));
    @(negedge ap_clk);
    areset = 1'b0;

    // Full 16-beat frame, no backpressure.
    run_frame(16, 16, 0, -1);
    check_frame("full", 16);
    if (q_data.size() > 0) begin
      check("full_lane0", OW'(q_data[0][63:0]), OW'(64'h0));
      check("full_lane7", OW'(q_data[0][IW*7 +: IW]), OW'(64'h0707070707070707));
    end
    check("full_busy",  OW'(busy_first), OW'(1));
    check("full_done_n", OW'(done_cnt), OW'(1));
    check("full_done_t", OW'(done_cyc), OW'(tl_cyc + 1));
    check("full_err",   OW'(err_len), OW'(0));

    // Partial tail: 11 beats, second output beat has 3 lanes.
    run_frame(11, 11, 0, -1);
    check_frame("part", 11);
    if (q_data.size() == 2) begin
      check("part_keep1", OW'(q_keep[1]), OW'(64'h0000_0000_00FF_FFFF));
      check("part_upper", OW'(q_data[1][OW-1:192]), OW'(0));
      check("part_lane2", OW'(q_data[1][IW*2 +: IW]), OW'(64'h0A0A0A0A0A0A0A0A));
    end
    check("part_done_n", OW'(done_cnt), OW'(1));

    // Backpressure 1-0-0-1: output holds stable while stalled.
    run_frame(16, 16, 1, -1);
    check_frame("bp", 16);
    check("bp_stalled", OW'(stall_cnt > 0), OW'(1));
    check("bp_stable",  OW'(stab_bad), OW'(0));
    check("bp_done_n",  OW'(done_cnt), OW'(1));

    // Long stall: full pack behind a held output register blocks input.
    run_frame(24, 24, 2, -1);
    check_frame("hold", 24);
    check("hold_seen",   OW'(held_cnt > 0), OW'(1));
    check("hold_sready", OW'(rdy_bad), OW'(0));
    check("hold_stable", OW'(stab_bad), OW'(0));

    // Zero-length frame.
    run_frame(0, 0, 0, -1);
    check("zero_vld",    OW'(vld_seen), OW'(0));
    check("zero_busy",   OW'(busy_cnt), OW'(0));
    check("zero_done_n", OW'(done_cnt), OW'(1));

    // Early tlast on beat 9 of a 16-beat frame.
    run_frame(16, 10, 0, -1);
    check_frame("early", 10);
    if (q_keep.size() == 2) check("early_keep1", OW'(q_keep[1]), OW'(64'hFFFF));
    check("early_err",    OW'(err_len), OW'(1));
    check("early_done_n", OW'(done_cnt), OW'(1));

    // Next start clears the sticky error.
    run_frame(16, 16, 0, -1);
    check("clr_err_start", OW'(err_first), OW'(0));
    check("clr_err_end",   OW'(err_len), OW'(0));
    check_frame("clr", 16);

    // Reset after 5 accepted beats of a 16-beat frame.
    run_frame(16, 16, 0, 5);
    check("abort_no_done", OW'(done_cnt), OW'(0));
    @(negedge ap_clk);
    areset = 1'b1;
    @(posedge ap_clk);
    #1;
    check("abort_mvalid", OW'(axis.m_axis_tvalid), OW'(0));
    check("abort_sready", OW'(axis.s_axis_tready), OW'(0));
    check("abort_busy",   OW'(busy), OW'(0));
    check("abort_done",   OW'(done), OW'(0));
    @(negedge ap_clk);
    areset = 1'b0;

    run_frame(8, 8, 0, -1);
    check_frame("post", 8);
    check("post_done_n", OW'(done_cnt), OW'(1));
    check("post_err",    OW'(err_len), OW'(0));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
